// File: rtl/timers_timer2_pkg.sv
// Shared definitions for the timer2 sequencing controller:
// FSM encodings, SFR address codes, flag-clear bit positions, TACP width.
package timers_timer2_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } t2_state_e;

    localparam logic [1:0] ADDR_TACPL = 2'd0;
    localparam logic [1:0] ADDR_TACPM = 2'd1;
    localparam logic [1:0] ADDR_TACPH = 2'd2;
    localparam logic [1:0] ADDR_CLR   = 2'd3;

    localparam int CLR_TF2_BIT   = 0;
    localparam int CLR_OVR_BIT   = 1;
    localparam int CLR_STALL_BIT = 2;

    localparam int TACP_W = 24;

endpackage

// File: rtl/timers_timer2_ctrl_shadow.sv
// Atomic 24-bit TACP reload: byte-wide shadow, written mask, committed copy.
// Ports: clk/rst_n, i_wr/i_addr/i_wdata (SFR write), i_permit (commit any
// time), i_ovf (commit point while running), o_tacp, o_pending.
module timers_timer2_ctrl_shadow (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr,
    input  logic [1:0]  i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_permit,
    input  logic        i_ovf,
    output logic [23:0] o_tacp,
    output logic        o_pending
);
    import timers_timer2_pkg::*;

    logic [TACP_W-1:0] r_shadow;
    logic [TACP_W-1:0] r_tacp;
    logic [2:0]        r_mask;
    logic [2:0]        w_wr_bit;
    logic              w_commit;

    always_comb begin
        w_wr_bit = 3'b000;
        if (i_wr) begin
            case (i_addr)
                ADDR_TACPL: w_wr_bit = 3'b001;
                ADDR_TACPM: w_wr_bit = 3'b010;
                ADDR_TACPH: w_wr_bit = 3'b100;
                default:    w_wr_bit = 3'b000;
            endcase
        end
    end

    // Mask is sampled from the register, so a write landing in the same
    // cycle as ovf never completes a commit at that pulse.
    assign w_commit = (&r_mask) & (i_permit | i_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_tacp   <= '0;
            r_mask   <= '0;
        end else begin
            if (w_commit)
                r_tacp <= r_shadow;
            r_mask <= (w_commit ? 3'b000 : r_mask) | w_wr_bit;
            if (w_wr_bit[0])
                r_shadow[7:0] <= i_wdata;
            if (w_wr_bit[1])
                r_shadow[15:8] <= i_wdata;
            if (w_wr_bit[2])
                r_shadow[23:16] <= i_wdata;
        end
    end

    assign o_tacp    = r_tacp;
    assign o_pending = |r_mask;

endmodule

// File: rtl/timers_timer2_ctrl.sv
// Timer2 sequencing controller: run/stop FSM, phase-stall watchdog, flags,
// IRQ, and TACP atomic reload (via shadow sub-module).
// Ports: clock/reset, tr2 run request, SFR write bus, pht/ovf pulses, ie;
// outputs TACP bytes, enable, TF2/ovr/stall flags, irq, pending, state.
module timers_timer2_ctrl #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       timers_timer2_ctrl_clock_i,
    input  logic       timers_timer2_ctrl_reset_i_b,
    input  logic       timers_sfr_tcon2_tr2_i,
    input  logic       timers_timer2_ctrl_wr_i,
    input  logic [1:0] timers_timer2_ctrl_addr_i,
    input  logic [7:0] timers_timer2_ctrl_wdata_i,
    input  logic       timers_timer2_ctrl_pht_i,
    input  logic       timers_timer2_ctrl_ovf_i,
    input  logic       timers_timer2_ctrl_ie_i,
    output logic [7:0] timers_sfr_tacpl_o,
    output logic [7:0] timers_sfr_tacpm_o,
    output logic [7:0] timers_sfr_tacph_o,
    output logic       timers_timer2_ctrl_enable_o,
    output logic       timers_sfr_tcon2_tf2_o,
    output logic       timers_timer2_ctrl_ovr_o,
    output logic       timers_timer2_ctrl_stall_o,
    output logic       timers_timer2_ctrl_irq_o,
    output logic       timers_timer2_ctrl_pending_o,
    output logic [1:0] timers_timer2_ctrl_state_o
);
    import timers_timer2_pkg::*;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic       clk;
    logic       rst_n;
    logic       w_tr2;
    logic       w_pht;
    logic       w_ovf;

    t2_state_e  r_state;
    t2_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic       w_timeout;
    logic       w_enable;
    logic       w_clr;
    logic       w_clr_tf2;
    logic       w_clr_ovr;
    logic       w_clr_stall;
    logic       r_tf2;
    logic       r_ovr;
    logic       r_stall;
    logic [23:0] w_tacp;
    logic       w_pending;

    assign clk   = timers_timer2_ctrl_clock_i;
    assign rst_n = timers_timer2_ctrl_reset_i_b;
    assign w_tr2 = timers_sfr_tcon2_tr2_i;
    assign w_pht = timers_timer2_ctrl_pht_i;
    assign w_ovf = timers_timer2_ctrl_ovf_i;

    assign w_timeout = (r_state == ST_RUN) & ~w_pht & (r_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_STOP;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; dropping tr2 overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_STOP: if (w_tr2) w_state_nxt = ST_ARM;
            ST_ARM:  if (w_pht) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_timeout) w_state_nxt = ST_ARM;
            default: w_state_nxt = ST_STOP;
        endcase
        if (!w_tr2)
            w_state_nxt = ST_STOP;
    end

    // Output decode
    always_comb begin
        w_enable = 1'b0;
        if (r_state == ST_RUN)
            w_enable = 1'b1;
    end

    // Watchdog: zero unless staying in RUN, so entry to RUN starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state != ST_RUN || w_state_nxt != ST_RUN)
            r_cnt <= '0;
        else if (w_pht)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_clr = timers_timer2_ctrl_wr_i &
                   (timers_timer2_ctrl_addr_i == ADDR_CLR);
    assign w_clr_tf2   = w_clr & timers_timer2_ctrl_wdata_i[CLR_TF2_BIT];
    assign w_clr_ovr   = w_clr & timers_timer2_ctrl_wdata_i[CLR_OVR_BIT];
    assign w_clr_stall = w_clr & timers_timer2_ctrl_wdata_i[CLR_STALL_BIT];

    // Sticky flags; a set in the same cycle as its clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tf2   <= 1'b0;
            r_ovr   <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_tf2   <= (r_tf2 & ~w_clr_tf2) | w_ovf;
            r_ovr   <= (r_ovr & ~w_clr_ovr) | (w_ovf & r_tf2);
            r_stall <= (r_stall & ~w_clr_stall) | w_timeout;
        end
    end

    timers_timer2_ctrl_shadow u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (timers_timer2_ctrl_wr_i),
        .i_addr    (timers_timer2_ctrl_addr_i),
        .i_wdata   (timers_timer2_ctrl_wdata_i),
        .i_permit  (r_state != ST_RUN),
        .i_ovf     (w_ovf),
        .o_tacp    (w_tacp),
        .o_pending (w_pending)
    );

    assign timers_sfr_tacpl_o           = w_tacp[7:0];
    assign timers_sfr_tacpm_o           = w_tacp[15:8];
    assign timers_sfr_tacph_o           = w_tacp[23:16];
    assign timers_timer2_ctrl_enable_o  = w_enable;
    assign timers_sfr_tcon2_tf2_o       = r_tf2;
    assign timers_timer2_ctrl_ovr_o     = r_ovr;
    assign timers_timer2_ctrl_stall_o   = r_stall;
    assign timers_timer2_ctrl_irq_o     = r_tf2 & timers_timer2_ctrl_ie_i;
    assign timers_timer2_ctrl_pending_o = w_pending;
    assign timers_timer2_ctrl_state_o   = r_state;

endmodule

// File: tb/tb_timers_timer2_ctrl.sv
// Directed bench for timers_timer2_ctrl (TIMEOUT_CYCLES=8).
// Hand-computed expectations checked with immediate assertions.
module tb_timers_timer2_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tr2;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       pht;
    logic       ovf;
    logic       ie;
    logic [7:0] tacpl;
    logic [7:0] tacpm;
    logic [7:0] tacph;
    logic       enable;
    logic       tf2;
    logic       ovr;
    logic       stall;
    logic       irq;
    logic       pending;
    logic [1:0] state;

    int total;
    int bad;

    timers_timer2_ctrl #(
        .CNT_W          (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .timers_timer2_ctrl_clock_i   (clk),
        .timers_timer2_ctrl_reset_i_b (rst_n),
        .timers_sfr_tcon2_tr2_i       (tr2),
        .timers_timer2_ctrl_wr_i      (wr),
        .timers_timer2_ctrl_addr_i    (addr),
        .timers_timer2_ctrl_wdata_i   (wdata),
        .timers_timer2_ctrl_pht_i     (pht),
        .timers_timer2_ctrl_ovf_i     (ovf),
        .timers_timer2_ctrl_ie_i      (ie),
        .timers_sfr_tacpl_o           (tacpl),
        .timers_sfr_tacpm_o           (tacpm),
        .timers_sfr_tacph_o           (tacph),
        .timers_timer2_ctrl_enable_o  (enable),
        .timers_sfr_tcon2_tf2_o       (tf2),
        .timers_timer2_ctrl_ovr_o     (ovr),
        .timers_timer2_ctrl_stall_o   (stall),
        .timers_timer2_ctrl_irq_o     (irq),
        .timers_timer2_ctrl_pending_o (pending),
        .timers_timer2_ctrl_state_o   (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
    endtask

    function automatic logic [31:0] tacp();
        return {8'h00, tacph, tacpm, tacpl};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        tr2   = 1'b0;
        wr    = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        pht   = 1'b0;
        ovf   = 1'b0;
        ie    = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_tacp", tacp(), 32'h0);
        chk("rst_tf2", 32'(tf2), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reload while stopped
        wreg(2'd0, 8'h34);
        tick();
        chk("stop_l_tacp", tacp(), 32'h0);
        chk("stop_l_pend", 32'(pending), 32'd1);
        wreg(2'd1, 8'h12);
        tick();
        chk("stop_m_tacp", tacp(), 32'h0);
        wreg(2'd2, 8'hAB);
        tick();
        chk("stop_h_tacp", tacp(), 32'h0);
        wr = 1'b0;
        tick();
        chk("stop_commit", tacp(), 32'hAB1234);
        chk("stop_pend0", 32'(pending), 32'd0);

        wreg(2'd0, 8'h10);
        tick();
        wreg(2'd1, 8'h00);
        tick();
        wreg(2'd2, 8'h00);
        tick();
        wr = 1'b0;
        tick();
        chk("tacp_10", tacp(), 32'h10);

        // STOP -> ARM -> RUN
        tr2 = 1'b1;
        tick();
        chk("arm_state", 32'(state), 32'd1);
        chk("arm_enable", 32'(enable), 32'd0);
        tick();
        tick();
        tick();
        chk("arm_hold", 32'(state), 32'd1);
        pht = 1'b1;
        tick();
        chk("run_state", 32'(state), 32'd2);
        chk("run_enable", 32'(enable), 32'd1);

        // reload in RUN waits for ovf (pht held to feed watchdog)
        ie = 1'b1;
        wreg(2'd2, 8'h00);
        tick();
        wreg(2'd1, 8'h00);
        tick();
        wreg(2'd0, 8'h20);
        tick();
        wr = 1'b0;
        tick();
        chk("run_hold1", tacp(), 32'h10);
        chk("run_pend", 32'(pending), 32'd1);
        tick();
        chk("run_hold2", tacp(), 32'h10);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        chk("run_commit", tacp(), 32'h20);
        chk("run_pend0", 32'(pending), 32'd0);
        chk("ovf_tf2", 32'(tf2), 32'd1);
        chk("ovf_irq", 32'(irq), 32'd1);
        chk("ovf_ovr0", 32'(ovr), 32'd0);

        wreg(2'd3, 8'h07);
        tick();
        wr = 1'b0;
        chk("clr_tf2", 32'(tf2), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);

        // final byte coincident with ovf
        wreg(2'd2, 8'h00);
        tick();
        wreg(2'd1, 8'h00);
        tick();
        wreg(2'd0, 8'h30);
        ovf = 1'b1;
        tick();
        wr  = 1'b0;
        ovf = 1'b0;
        chk("coin_nocommit", tacp(), 32'h20);
        chk("coin_pend", 32'(pending), 32'd1);
        chk("coin_tf2", 32'(tf2), 32'd1);
        chk("coin_ovr0", 32'(ovr), 32'd0);
        tick();
        chk("coin_hold", tacp(), 32'h20);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        chk("coin_commit", tacp(), 32'h30);
        chk("coin_pend0", 32'(pending), 32'd0);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_irq", 32'(irq), 32'd1);
        ie = 1'b0;
        #1;
        chk("irq_ie0", 32'(irq), 32'd0);
        ie = 1'b1;

        // set wins over clear
        wreg(2'd3, 8'h03);
        ovf = 1'b1;
        tick();
        wr  = 1'b0;
        ovf = 1'b0;
        chk("setwin_tf2", 32'(tf2), 32'd1);
        chk("setwin_ovr", 32'(ovr), 32'd1);

        wreg(2'd3, 8'h07);
        tick();
        wr  = 1'b0;
        pht = 1'b0;
        chk("clrall_tf2", 32'(tf2), 32'd0);
        chk("clrall_ovr", 32'(ovr), 32'd0);

        // watchdog: pht on the 7th cycle restarts the count
        repeat (6) tick();
        chk("wd_run6", 32'(state), 32'd2);
        pht = 1'b1;
        tick();
        pht = 1'b0;
        tick();
        chk("wd_nostall", 32'(stall), 32'd0);
        chk("wd_run8", 32'(state), 32'd2);
        repeat (6) tick();
        chk("wd_pre_state", 32'(state), 32'd2);
        chk("wd_pre_stall", 32'(stall), 32'd0);
        tick();
        chk("wd_stall", 32'(stall), 32'd1);
        chk("wd_arm", 32'(state), 32'd1);
        chk("wd_enable0", 32'(enable), 32'd0);

        wreg(2'd3, 8'h04);
        tick();
        wr = 1'b0;
        chk("clr_stall", 32'(stall), 32'd0);

        // tr2 drop in ARM and in RUN
        tr2 = 1'b0;
        tick();
        chk("drop_arm", 32'(state), 32'd0);
        tr2 = 1'b1;
        tick();
        chk("rearm", 32'(state), 32'd1);
        pht = 1'b1;
        tick();
        pht = 1'b0;
        chk("rerun", 32'(state), 32'd2);
        tr2 = 1'b0;
        tick();
        chk("drop_run", 32'(state), 32'd0);
        chk("drop_enable", 32'(enable), 32'd0);

        // async reset discards a partial reload
        wreg(2'd0, 8'h55);
        tick();
        wreg(2'd1, 8'h66);
        tick();
        wr = 1'b0;
        chk("part_pend", 32'(pending), 32'd1);
        chk("part_tacp", tacp(), 32'h30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_tacp", tacp(), 32'h0);
        chk("arst_state", 32'(state), 32'd0);
        #5;
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
